// File: rtl/quad_decoder_pkg.sv
// quad_pkg: shared definitions for the quadrature decoder.
//   quad_state_t  decoded channel state {A, B}
//   DIR_UP/DIR_DOWN  direction encoding (matches the counter mode sense)
//   quad_step_t   result of classifying a state change {legal, dir}
//   up_next/down_next/classify  Gray-code sequence helpers
package quad_pkg;

   typedef enum logic [1:0] {
      S00 = 2'b00,
      S01 = 2'b01,
      S10 = 2'b10,
      S11 = 2'b11
   } quad_state_t;

   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

   typedef struct packed {
      logic legal;
      logic dir;
   } quad_step_t;

   // Up sequence: 00 -> 10 -> 11 -> 01 -> 00
   function automatic quad_state_t up_next(input quad_state_t s);
      quad_state_t n;
      case (s)
         S00:     n = S10;
         S10:     n = S11;
         S11:     n = S01;
         default: n = S00;
      endcase
      return n;
   endfunction

   // Down sequence: 00 -> 01 -> 11 -> 10 -> 00
   function automatic quad_state_t down_next(input quad_state_t s);
      quad_state_t n;
      case (s)
         S00:     n = S01;
         S01:     n = S11;
         S11:     n = S10;
         default: n = S00;
      endcase
      return n;
   endfunction

   // legal=1 only for a single-bit move along either sequence;
   // an unchanged or double-bit change reports legal=0.
   function automatic quad_step_t classify(input quad_state_t prev,
                                           input quad_state_t cur);
      quad_step_t r;
      r.legal = 1'b0;
      r.dir   = DIR_UP;
      if (cur == up_next(prev)) begin
         r.legal = 1'b1;
         r.dir   = DIR_UP;
      end else if (cur == down_next(prev)) begin
         r.legal = 1'b1;
         r.dir   = DIR_DOWN;
      end
      return r;
   endfunction

endpackage

// File: rtl/quad_input_filter.sv
// quad_input_filter: synchroniser plus stability filter for one encoder channel.
//   clk    rising-edge clock
//   reset  synchronous, active-high
//   din    raw channel, asynchronous to clk
//   dout   filtered channel; follows the synchronised value only after it
//          has differed from dout for FILTER consecutive cycles
module quad_input_filter #(
   parameter int SYNC_STAGES = 2,
   parameter int FILTER      = 3
) (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic dout
);

   localparam int CW = (FILTER > 1) ? $clog2(FILTER) : 1;

   logic [SYNC_STAGES-1:0] sync;
   logic [CW-1:0]          run;
   logic                   synced;

   assign synced = sync[SYNC_STAGES-1];

   always_ff @(posedge clk) begin
      if (reset) begin
         sync <= '0;
         run  <= '0;
         dout <= 1'b0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], din};
         // run counts differing samples already seen; the FILTER-th one commits
         if (synced == dout) begin
            run <= '0;
         end else if (run == CW'(FILTER - 1)) begin
            dout <= synced;
            run  <= '0;
         end else begin
            run <= run + 1'b1;
         end
      end
   end

endmodule

// File: rtl/quad_decoder.sv
// quad_decoder: two-phase incremental encoder to step/dir/position.
//   clk, reset              clock, synchronous active-high reset
//   enc_a, enc_b            raw encoder channels (asynchronous)
//   clear                   load position with 0
//   preset_en, preset_val   load position with preset_val
//   err_clr                 clear the sticky error flag
//   position                wrapping position count
//   step                    one-cycle pulse per legal transition
//   dir                     direction of last step (0 up, 1 down)
//   err                     sticky illegal (double-edge) transition flag
module quad_decoder
   import quad_pkg::*;
#(
   parameter int WIDTH       = 16,
   parameter int SYNC_STAGES = 2,
   parameter int FILTER      = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enc_a,
   input  logic             enc_b,
   input  logic             clear,
   input  logic             preset_en,
   input  logic [WIDTH-1:0] preset_val,
   input  logic             err_clr,
   output logic [WIDTH-1:0] position,
   output logic             step,
   output logic             dir,
   output logic             err
);

   // Filters restart from 0 on reset, so the real pin levels only reach
   // the decoder after the pipeline has refilled; arming waits that long
   // so the settled state is captured as the reference, not a step.
   localparam int ARM_CYCLES = SYNC_STAGES + FILTER;
   localparam int AW         = $clog2(ARM_CYCLES + 1);

   logic        a_f;
   logic        b_f;
   quad_state_t cur;
   quad_state_t prev;
   logic        armed;
   logic [AW-1:0] arm_cnt;
   quad_step_t  cls;
   logic        changed;
   logic        legal_step;
   logic        illegal;

   quad_input_filter #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILTER     (FILTER)
   ) u_filt_a (
      .clk  (clk),
      .reset(reset),
      .din  (enc_a),
      .dout (a_f)
   );

   quad_input_filter #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILTER     (FILTER)
   ) u_filt_b (
      .clk  (clk),
      .reset(reset),
      .din  (enc_b),
      .dout (b_f)
   );

   assign cur = quad_state_t'({a_f, b_f});

   always_comb begin
      cls        = classify(prev, cur);
      changed    = armed && (cur != prev);
      legal_step = changed && cls.legal;
      illegal    = changed && !cls.legal;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         armed    <= 1'b0;
         arm_cnt  <= '0;
         prev     <= S00;
         position <= '0;
         step     <= 1'b0;
         dir      <= DIR_UP;
         err      <= 1'b0;
      end else begin
         // prev always follows the filtered state, so an illegal change
         // also becomes the new reference
         prev <= cur;
         step <= legal_step;

         if (!armed) begin
            if (arm_cnt == AW'(ARM_CYCLES)) begin
               armed <= 1'b1;
            end else begin
               arm_cnt <= arm_cnt + 1'b1;
            end
         end

         if (clear) begin
            position <= '0;
         end else if (preset_en) begin
            position <= preset_val;
         end else if (legal_step) begin
            position <= (cls.dir == DIR_DOWN) ? position - 1'b1 : position + 1'b1;
         end

         if (legal_step) begin
            dir <= cls.dir;
         end

         if (illegal) begin
            err <= 1'b1;
         end else if (err_clr) begin
            err <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_quad_decoder.sv
module tb_quad_decoder;

   localparam int WIDTH = 16;
   localparam int LAT   = 2 + 3 + 1;

   logic             clk;
   logic             reset;
   logic             enc_a;
   logic             enc_b;
   logic             clear;
   logic             preset_en;
   logic [WIDTH-1:0] preset_val;
   logic             err_clr;
   logic [WIDTH-1:0] position;
   logic             step;
   logic             dir;
   logic             err;

   int errors;
   int checks;
   int step_cnt;

   // reference model: pin state, position, direction, error, step total
   logic             ma;
   logic             mb;
   logic [WIDTH-1:0] m_pos;
   logic             m_dir;
   logic             m_err;
   int               m_steps;

   quad_decoder #(
      .WIDTH      (WIDTH),
      .SYNC_STAGES(2),
      .FILTER     (3)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .enc_a     (enc_a),
      .enc_b     (enc_b),
      .clear     (clear),
      .preset_en (preset_en),
      .preset_val(preset_val),
      .err_clr   (err_clr),
      .position  (position),
      .step      (step),
      .dir       (dir),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (step === 1'b1) step_cnt++;
   end

   // position of a Gray state within the up sequence 00,10,11,01
   function automatic int gidx(input logic a, input logic b);
      if (!a && !b) return 0;
      if (a && !b) return 1;
      if (a && b) return 2;
      return 3;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic apply_model(input logic na, input logic nb);
      int d;
      d = (gidx(na, nb) - gidx(ma, mb) + 4) % 4;
      if (d == 1) begin
         m_pos = m_pos + 1;
         m_dir = 1'b0;
         m_steps++;
      end else if (d == 3) begin
         m_pos = m_pos - 1;
         m_dir = 1'b1;
         m_steps++;
      end else if (d == 2) begin
         m_err = 1'b1;
      end
      ma = na;
      mb = nb;
   endtask

   task automatic edge_to(input logic na, input logic nb);
      apply_model(na, nb);
      enc_a = na;
      enc_b = nb;
      idle(10);
   endtask

   task automatic up_edge();
      int i;
      i = (gidx(ma, mb) + 1) % 4;
      edge_to(i == 1 || i == 2, i == 2 || i == 3);
   endtask

   task automatic down_edge();
      int i;
      i = (gidx(ma, mb) + 3) % 4;
      edge_to(i == 1 || i == 2, i == 2 || i == 3);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle(3);
      reset = 1'b0;
      checks++;
      if (position !== '0) begin
         errors++; $display("FAIL reset_position: got %0h expected 0", position);
      end
      checks++;
      if (step !== 1'b0 || dir !== 1'b0 || err !== 1'b0) begin
         errors++; $display("FAIL reset_flags: got step=%b dir=%b err=%b expected 000", step, dir, err);
      end
      idle(10);
      checks++;
      if (step_cnt != 0 || err !== 1'b0) begin
         errors++; $display("FAIL reset_arm: got steps=%0d err=%b expected 0 0", step_cnt, err);
      end
   endtask

   task automatic test_up_cycles();
      int s0;
      s0 = step_cnt;
      for (int i = 0; i < 16; i++) up_edge();
      checks++;
      if (step_cnt - s0 != 16) begin
         errors++; $display("FAIL up_steps: got %0d expected 16", step_cnt - s0);
      end
      checks++;
      if (position !== 16'd16) begin
         errors++; $display("FAIL up_position: got %0h expected 10", position);
      end
      checks++;
      if (dir !== 1'b0 || err !== 1'b0) begin
         errors++; $display("FAIL up_flags: got dir=%b err=%b expected 0 0", dir, err);
      end
   endtask

   task automatic test_latency();
      int i;
      int lat;
      lat = 0;
      i = (gidx(ma, mb) + 1) % 4;
      apply_model(i == 1 || i == 2, i == 2 || i == 3);
      enc_a = ma;
      enc_b = mb;
      for (int k = 1; k <= 20 && lat == 0; k++) begin
         tick();
         if (step === 1'b1) lat = k;
      end
      checks++;
      if (lat != LAT) begin
         errors++; $display("FAIL latency: got %0d cycles expected %0d", lat, LAT);
      end
      idle(10);
      checks++;
      if (position !== m_pos) begin
         errors++; $display("FAIL latency_position: got %0h expected %0h", position, m_pos);
      end
   endtask

   task automatic test_preset_down();
      int s0;
      preset_val = 16'h0002;
      preset_en  = 1'b1;
      tick();
      preset_en  = 1'b0;
      m_pos      = 16'h0002;
      checks++;
      if (position !== 16'h0002) begin
         errors++; $display("FAIL preset_load: got %0h expected 2", position);
      end
      s0 = step_cnt;
      for (int i = 0; i < 3; i++) down_edge();
      checks++;
      if (position !== 16'hFFFF) begin
         errors++; $display("FAIL down_wrap: got %0h expected ffff", position);
      end
      checks++;
      if (dir !== 1'b1 || step_cnt - s0 != 3) begin
         errors++; $display("FAIL down_steps: got dir=%b steps=%0d expected 1 3", dir, step_cnt - s0);
      end
   endtask

   task automatic test_glitch();
      int s0;
      logic d0;
      s0 = step_cnt;
      enc_a = ~ma;
      idle(2);
      enc_a = ma;
      idle(12);
      checks++;
      if (step_cnt != s0 || position !== m_pos) begin
         errors++; $display("FAIL glitch_reject: got steps=%0d pos=%0h expected %0d %0h", step_cnt, position, s0, m_pos);
      end
      apply_model(~ma, mb);
      d0 = m_dir;
      apply_model(~ma, mb);
      enc_a = ~enc_a;
      idle(3);
      enc_a = ~enc_a;
      idle(12);
      checks++;
      if (step_cnt - s0 != 2 || position !== m_pos) begin
         errors++; $display("FAIL pulse_accept: got steps=%0d pos=%0h expected 2 %0h", step_cnt - s0, position, m_pos);
      end
      checks++;
      if (dir !== m_dir || m_dir == d0) begin
         errors++; $display("FAIL pulse_dir: got %b expected %b", dir, m_dir);
      end
   endtask

   task automatic test_illegal();
      int s0;
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      m_err = 1'b0;
      s0 = step_cnt;
      edge_to(~ma, ~mb);
      checks++;
      if (err !== 1'b1 || step_cnt != s0 || position !== m_pos || dir !== m_dir) begin
         errors++; $display("FAIL illegal_first: got err=%b steps=%0d pos=%0h dir=%b expected 1 %0d %0h %b",
                            err, step_cnt, position, dir, s0, m_pos, m_dir);
      end
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      m_err = 1'b0;
      checks++;
      if (err !== 1'b0) begin
         errors++; $display("FAIL err_clear: got %b expected 0", err);
      end
      apply_model(~ma, ~mb);
      enc_a = ma;
      enc_b = mb;
      idle(LAT - 1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      checks++;
      if (err !== 1'b1) begin
         errors++; $display("FAIL err_set_priority: got %b expected 1", err);
      end
      idle(10);
      checks++;
      if (step_cnt != s0 || position !== m_pos) begin
         errors++; $display("FAIL illegal_second: got steps=%0d pos=%0h expected %0d %0h", step_cnt, position, s0, m_pos);
      end
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      m_err = 1'b0;
   endtask

   task automatic test_clear_step();
      int i;
      preset_val = 16'd5;
      preset_en  = 1'b1;
      tick();
      preset_en  = 1'b0;
      m_pos      = 16'd5;
      i = (gidx(ma, mb) + 1) % 4;
      apply_model(i == 1 || i == 2, i == 2 || i == 3);
      m_pos = '0;
      enc_a = ma;
      enc_b = mb;
      idle(LAT - 1);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      checks++;
      if (step !== 1'b1 || dir !== 1'b0 || position !== '0) begin
         errors++; $display("FAIL clear_with_step: got step=%b dir=%b pos=%0h expected 1 0 0", step, dir, position);
      end
      idle(10);
   endtask

   task automatic test_reset_mid();
      int s0;
      while (!(ma && mb)) up_edge();
      preset_val = 16'd7;
      preset_en  = 1'b1;
      tick();
      preset_en  = 1'b0;
      m_pos      = 16'd7;
      checks++;
      if (position !== 16'd7) begin
         errors++; $display("FAIL mid_preset: got %0h expected 7", position);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      m_pos = '0;
      m_dir = 1'b0;
      m_err = 1'b0;
      checks++;
      if (position !== '0 || dir !== 1'b0 || err !== 1'b0 || step !== 1'b0) begin
         errors++; $display("FAIL mid_reset: got pos=%0h dir=%b err=%b step=%b expected 0 0 0 0", position, dir, err, step);
      end
      s0 = step_cnt;
      idle(20);
      checks++;
      if (step_cnt != s0 || err !== 1'b0 || position !== '0) begin
         errors++; $display("FAIL rearm_silent: got steps=%0d err=%b pos=%0h expected %0d 0 0", step_cnt, err, position, s0);
      end
      up_edge();
      checks++;
      if (position !== 16'd1 || dir !== 1'b0 || step_cnt != s0 + 1) begin
         errors++; $display("FAIL rearm_count: got pos=%0h dir=%b steps=%0d expected 1 0 %0d", position, dir, step_cnt, s0 + 1);
      end
      m_steps = step_cnt;
   endtask

   task automatic test_random();
      int r;
      int g;
      m_steps = step_cnt;
      for (int it = 0; it < 40; it++) begin
         r = $urandom_range(0, 9);
         if (r <= 2) begin
            edge_to(~ma, mb);
         end else if (r <= 5) begin
            edge_to(ma, ~mb);
         end else if (r == 6) begin
            edge_to(~ma, ~mb);
         end else if (r == 7) begin
            g = $urandom_range(1, 2);
            if ($urandom_range(0, 1) == 0) enc_a = ~ma; else enc_b = ~mb;
            idle(g);
            enc_a = ma;
            enc_b = mb;
            idle(10);
         end else if (r == 8) begin
            preset_val = WIDTH'($urandom);
            preset_en  = 1'b1;
            tick();
            preset_en  = 1'b0;
            m_pos      = preset_val;
            idle(2);
         end else begin
            if ($urandom_range(0, 1) == 0) begin
               clear = 1'b1;
               m_pos = '0;
            end else begin
               err_clr = 1'b1;
               m_err   = 1'b0;
            end
            tick();
            clear   = 1'b0;
            err_clr = 1'b0;
            idle(2);
         end
         checks++;
         if (position !== m_pos) begin
            errors++; $display("FAIL rand_position[%0d]: got %0h expected %0h", it, position, m_pos);
         end
         checks++;
         if (err !== m_err) begin
            errors++; $display("FAIL rand_err[%0d]: got %b expected %b", it, err, m_err);
         end
         checks++;
         if (dir !== m_dir) begin
            errors++; $display("FAIL rand_dir[%0d]: got %b expected %b", it, dir, m_dir);
         end
         checks++;
         if (step_cnt != m_steps) begin
            errors++; $display("FAIL rand_steps[%0d]: got %0d expected %0d", it, step_cnt, m_steps);
         end
      end
   endtask

   initial begin
      errors     = 0;
      checks     = 0;
      step_cnt   = 0;
      reset      = 1'b1;
      enc_a      = 1'b0;
      enc_b      = 1'b0;
      clear      = 1'b0;
      preset_en  = 1'b0;
      preset_val = '0;
      err_clr    = 1'b0;
      ma         = 1'b0;
      mb         = 1'b0;
      m_pos      = '0;
      m_dir      = 1'b0;
      m_err      = 1'b0;
      m_steps    = 0;

      test_reset();
      test_up_cycles();
      test_latency();
      test_preset_down();
      test_glitch();
      test_illegal();
      test_clear_step();
      test_reset_mid();
      test_random();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
